// File: rtl/cmd_seq.sv
// cmd_seq: buffered line-follower command sequencer. Queues packed 2-bit opcode words
// and steps veer/turn manoeuvres. Optional feature macro: LINE_TIMEOUT_EN (line-lost abort).
module cmd_seq #(
   parameter int CMD_W = 16,
   parameter int DEPTH = 4,
   parameter int ERR_W = 12,
   parameter int TMR_W = 26,
   parameter logic [ERR_W-1:0] VEER_MAG   = 12'h340,
   parameter logic [ERR_W-1:0] TURN_A_MAG = 12'h1E0,
   parameter logic [ERR_W-1:0] TURN_B_MAG = 12'h380,
   parameter logic [TMR_W-1:0] TURN_A_CNT = 26'h0A0000,
   parameter logic [TMR_W-1:0] TURN_B_CNT = 26'h100000,
   parameter logic [TMR_W-1:0] DBNC_CNT   = 26'h1FFFF,
   parameter logic [TMR_W-1:0] LOST_CNT   = 26'h3FFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CMD_W-1:0] cmd,
   input  logic             cmd_rdy,
   output logic             clr_cmd_rdy,
   input  logic             line_present,
   input  logic             BMPL_n,
   input  logic             BMPR_n,
   output logic             go,
   output logic [ERR_W-1:0] err_opn_lp,
   output logic             buzz,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             aborted
);

   localparam int STEPS = CMD_W / 2;
   localparam int SW    = $clog2(STEPS + 1);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam logic [SW-1:0] STEPS_C = SW'(STEPS);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [2:0] {
      IDLE, LOAD, MOVE, VEER, TURN_A, TURN_B, COLLISION
   } state_t;

   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;

   state_t           state_q;
   logic [CMD_W-1:0] cur_q;
   logic [SW-1:0]    step_q;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             last_right_q;
   logic             go_q, buzz_q;
   logic [ERR_W-1:0] err_q;
   logic [1:0]       op_d;
   logic             push, pop, lost_abort;

   function automatic logic [ERR_W-1:0] signed_mag(input logic right, input logic [ERR_W-1:0] mag);
      return right ? mag : ({ERR_W{1'b0}} - mag);
   endfunction

   // A word whose step budget is spent behaves exactly like an explicit end opcode.
   always_comb begin
      timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
      op_d    = (step_q >= STEPS_C) ? 2'b00 : cur_q[1:0];
   end

   assign fifo_full   = (count_q == DEPTH_C);
   assign fifo_empty  = (count_q == '0);
   assign push        = cmd_rdy && !fifo_full && !rst && !lost_abort;
   assign pop         = (state_q == LOAD) && !fifo_empty;
   assign clr_cmd_rdy = push;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd;
   end

   always_ff @(posedge clk) begin
      if (rst || lost_abort) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

`ifdef LINE_TIMEOUT_EN
   logic aborted_q;

   // TURN_B only becomes abortable once its steering phase has elapsed.
   assign lost_abort = !line_present && (timer_q >= LOST_CNT) &&
                       ((state_q == VEER) || ((state_q == TURN_B) && (timer_q >= TURN_B_CNT)));

   always_ff @(posedge clk) begin
      if (rst)             aborted_q <= 1'b0;
      else if (lost_abort) aborted_q <= 1'b1;
      else if (push)       aborted_q <= 1'b0;
   end

   assign aborted = aborted_q;
`else
   assign lost_abort = 1'b0;
   assign aborted    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cur_q        <= '0;
         step_q       <= '0;
         timer_q      <= '0;
         last_right_q <= 1'b1;
         go_q         <= 1'b0;
         err_q        <= '0;
         buzz_q       <= 1'b0;
      end else if (lost_abort) begin
         state_q <= IDLE;
         timer_q <= '0;
         go_q    <= 1'b0;
         err_q   <= '0;
      end else begin
         timer_q <= timer_d;
         case (state_q)
            IDLE: begin
               go_q  <= 1'b0;
               err_q <= '0;
               if (!fifo_empty && line_present) state_q <= LOAD;
            end
            LOAD: begin
               cur_q   <= mem_q[rd_ptr_q];
               step_q  <= '0;
               timer_q <= '0;
               go_q    <= 1'b1;
               err_q   <= '0;
               state_q <= MOVE;
            end
            MOVE: begin
               if (!BMPL_n || !BMPR_n) begin
                  state_q <= COLLISION;
                  go_q    <= 1'b0;
                  err_q   <= '0;
                  buzz_q  <= 1'b1;
                  timer_q <= '0;
               end else if (line_present) begin
                  go_q  <= 1'b1;
                  err_q <= '0;
               end else begin
                  case (op_d)
                     2'b11: begin
                        state_q <= TURN_A;
                        go_q    <= 1'b0;
                        err_q   <= '0;
                        timer_q <= '0;
                     end
                     2'b01, 2'b10: begin
                        state_q <= VEER;
                        go_q    <= 1'b1;
                        err_q   <= signed_mag(cur_q[0], VEER_MAG);
                        timer_q <= '0;
                     end
                     default: begin
                        err_q <= '0;
                        if (!fifo_empty) begin
                           state_q <= LOAD;
                           go_q    <= 1'b1;
                        end else begin
                           state_q <= IDLE;
                           go_q    <= 1'b0;
                        end
                     end
                  endcase
               end
            end
            VEER: begin
               go_q <= 1'b1;
               if (line_present) begin
                  cur_q        <= cur_q >> 2;
                  step_q       <= step_q + 1'b1;
                  last_right_q <= cur_q[0];
                  err_q        <= '0;
                  state_q      <= MOVE;
               end else begin
                  err_q <= signed_mag(cur_q[0], VEER_MAG);
               end
            end
            TURN_A: begin
               if (timer_q >= TURN_A_CNT) begin
                  go_q    <= 1'b0;
                  err_q   <= '0;
                  timer_q <= '0;
                  state_q <= TURN_B;
               end else begin
                  go_q  <= 1'b1;
                  err_q <= signed_mag(last_right_q, TURN_A_MAG);
               end
            end
            TURN_B: begin
               go_q <= 1'b1;
               if (timer_q < TURN_B_CNT) begin
                  err_q <= signed_mag(last_right_q, TURN_B_MAG);
               end else begin
                  err_q <= '0;
                  if (line_present) begin
                     cur_q   <= cur_q >> 2;
                     step_q  <= step_q + 1'b1;
                     state_q <= MOVE;
                  end
               end
            end
            COLLISION: begin
               if (BMPL_n && BMPR_n) begin
                  state_q <= MOVE;
                  buzz_q  <= 1'b0;
                  go_q    <= 1'b1;
                  err_q   <= '0;
               end else begin
                  go_q <= 1'b0;
                  if (timer_q >= DBNC_CNT) begin
                     buzz_q  <= ~buzz_q;
                     timer_q <= '0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign go         = go_q;
   assign err_opn_lp = err_q;
   assign buzz       = buzz_q;

endmodule

// File: tb/tb_cmd_seq.sv
// tb_cmd_seq: randomized self-checking bench for cmd_seq with a word-level reference
// model (opcode decode, FIFO order, last-veer direction) and short phase timings.
module tb_cmd_seq;

   localparam int CMD_W = 16;
   localparam int STEPS = CMD_W / 2;
   localparam int TA    = 20;
   localparam int TB    = 30;
   localparam int DB    = 10;
   localparam int LOST  = 200;
   localparam logic [11:0] VEER_M = 12'h340;
   localparam logic [11:0] TA_M   = 12'h1E0;
   localparam logic [11:0] TB_M   = 12'h380;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        line_present;
   logic        BMPL_n, BMPR_n;
   logic        go;
   logic [11:0] err_opn_lp;
   logic        buzz;
   logic        fifo_full, fifo_empty, aborted;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] wordQ[$];
   logic        lastRight;

   cmd_seq #(
      .CMD_W(16), .DEPTH(4), .ERR_W(12), .TMR_W(26),
      .VEER_MAG(VEER_M), .TURN_A_MAG(TA_M), .TURN_B_MAG(TB_M),
      .TURN_A_CNT(26'(TA)), .TURN_B_CNT(26'(TB)),
      .DBNC_CNT(26'(DB)), .LOST_CNT(26'(LOST))
   ) dut (
      .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
      .line_present(line_present), .BMPL_n(BMPL_n), .BMPR_n(BMPR_n),
      .go(go), .err_opn_lp(err_opn_lp), .buzz(buzz),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .aborted(aborted)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [11:0] expErr(input logic right, input logic [11:0] mag);
      return right ? mag : 12'(-int'(mag));
   endfunction

   function automatic logic [15:0] randWord();
      logic [15:0] w;
      int n;
      w = '0;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) w = w | (16'($urandom_range(1, 3)) << (2 * i));
      return w;
   endfunction

   task automatic applyStimulus(input logic [15:0] w);
      logic acc;
      acc = 1'b0;
      cmd = w;
      cmd_rdy = 1'b1;
      for (int i = 0; i < 10 && !acc; i++) begin
         #1;
         if (clr_cmd_rdy) acc = 1'b1;
         @(negedge clk);
      end
      cmd_rdy = 1'b0;
      checkOutput("pushAck", 32'(acc), 32'(1));
      if (acc) wordQ.push_back(w);
   endtask

   task automatic startFromIdle();
      line_present = 1'b1;
      @(negedge clk);
      checkOutput("goDuringLoad", 32'(go), 32'(0));
      @(negedge clk);
      checkOutput("goAfter2", 32'(go), 32'(1));
      tick(3);
   endtask

   task automatic runOp(input logic [1:0] op);
      int nA, nB, goLow;
      logic [11:0] eA, eB;
      nA = 0; nB = 0; goLow = 0;
      if (line_present) begin
         checkOutput("moveErr", 32'(err_opn_lp), 32'(0));
         checkOutput("moveGo", 32'(go), 32'(1));
      end
      line_present = 1'b0;
      if (op != 2'b11) begin
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!go) goLow++;
         end
         checkOutput("veerErr", 32'(err_opn_lp), 32'(expErr(op == 2'b01, VEER_M)));
         checkOutput("veerGoLow", 32'(goLow), 32'(0));
         lastRight = (op == 2'b01);
      end else begin
         eA = expErr(lastRight, TA_M);
         eB = expErr(lastRight, TB_M);
         for (int i = 0; i < TA + TB + 15; i++) begin
            @(negedge clk);
            if (err_opn_lp == eA) nA++;
            if (err_opn_lp == eB) nB++;
            if (!go) goLow++;
         end
         checkOutput("turnACycles", 32'(nA), 32'(TA));
         checkOutput("turnBCycles", 32'(nB), 32'(TB));
         checkOutput("turnGoLow", 32'(goLow), 32'(2));
         checkOutput("turnWaitErr", 32'(err_opn_lp), 32'(0));
         checkOutput("turnWaitGo", 32'(go), 32'(1));
      end
      line_present = 1'b1;
      tick(3);
      checkOutput("rejoinErr", 32'(err_opn_lp), 32'(0));
      checkOutput("rejoinGo", 32'(go), 32'(1));
   endtask

   task automatic runQueue();
      logic [15:0] w;
      logic [1:0]  op;
      while (wordQ.size() > 0) begin
         w = wordQ.pop_front();
         for (int i = 0; i < STEPS; i++) begin
            op = 2'(w >> (2 * i));
            if (op == 2'b00) break;
            runOp(op);
         end
         line_present = 1'b0;
         if (wordQ.size() == 0) begin
            tick(5);
            checkOutput("idleGo", 32'(go), 32'(0));
            checkOutput("idleErr", 32'(err_opn_lp), 32'(0));
            checkOutput("idleEmpty", 32'(fifo_empty), 32'(1));
         end
      end
   endtask

   initial begin
      logic        acc;
      int          lat, pulses, toggles, goHigh;
      logic        prevBuzz;
      logic [15:0] w5;
      int          hold;

      rst = 1'b1; cmd = '0; cmd_rdy = 1'b1; line_present = 1'b0;
      BMPL_n = 1'b1; BMPR_n = 1'b1; lastRight = 1'b1;
      tick(3);
      #1;
      checkOutput("rstClr", 32'(clr_cmd_rdy), 32'(0));
      checkOutput("rstGo", 32'(go), 32'(0));
      checkOutput("rstErr", 32'(err_opn_lp), 32'(0));
      checkOutput("rstBuzz", 32'(buzz), 32'(0));
      checkOutput("rstEmpty", 32'(fifo_empty), 32'(1));
      checkOutput("rstFull", 32'(fifo_full), 32'(0));
      checkOutput("rstAborted", 32'(aborted), 32'(0));
      @(negedge clk);
      rst = 1'b0; cmd_rdy = 1'b0;
      tick(1);

      // single right veer, then end of word
      applyStimulus(16'h0001);
      checkOutput("emptyAfterPush", 32'(fifo_empty), 32'(0));
      startFromIdle();
      runQueue();

      applyStimulus(16'h0006);
      startFromIdle();
      runQueue();
      applyStimulus(16'h000E);
      startFromIdle();
      runQueue();

      // fill the FIFO and hold a fifth word until the first pop frees a slot
      for (int i = 0; i < 4; i++) applyStimulus(randWord());
      checkOutput("fullAfter4", 32'(fifo_full), 32'(1));
      w5 = randWord();
      cmd = w5; cmd_rdy = 1'b1; pulses = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (clr_cmd_rdy) pulses++;
         @(negedge clk);
      end
      checkOutput("heldWhileFull", 32'(pulses), 32'(0));
      line_present = 1'b1; acc = 1'b0; lat = -1;
      for (int i = 0; i < 10 && !acc; i++) begin
         #1;
         if (clr_cmd_rdy) begin acc = 1'b1; lat = i; end
         @(negedge clk);
      end
      cmd_rdy = 1'b0;
      checkOutput("fifthAccepted", 32'(acc), 32'(1));
      checkOutput("fifthLatency", 32'(lat), 32'(2));
      if (acc) wordQ.push_back(w5);
      tick(2);
      runQueue();

      applyStimulus(16'h0001);
      applyStimulus(16'h0002);
      startFromIdle();
      runQueue();

      // reset during a left veer: queue flushed, turn direction back to right
      applyStimulus(16'h0002);
      applyStimulus(16'h0001);
      startFromIdle();
      line_present = 1'b0;
      tick(5);
      checkOutput("preResetErr", 32'(err_opn_lp), 32'(expErr(1'b0, VEER_M)));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midRstGo", 32'(go), 32'(0));
      checkOutput("midRstErr", 32'(err_opn_lp), 32'(0));
      checkOutput("midRstEmpty", 32'(fifo_empty), 32'(1));
      wordQ.delete();
      lastRight = 1'b1;
      line_present = 1'b1;
      tick(3);
      checkOutput("idleStay", 32'(go), 32'(0));
      line_present = 1'b0;
      tick(1);
      applyStimulus(16'h0003);
      startFromIdle();
      runQueue();

      // collision: buzz toggles every DB+1 cycles while a bumper is held
      applyStimulus(16'h0001);
      startFromIdle();
      BMPL_n = 1'b0;
      @(negedge clk);
      checkOutput("buzzOn", 32'(buzz), 32'(1));
      hold = 3 * (DB + 1) + (DB + 1) / 2;
      toggles = 0; goHigh = 0; prevBuzz = buzz;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (buzz != prevBuzz) toggles++;
         prevBuzz = buzz;
         if (go) goHigh++;
      end
      checkOutput("buzzToggles", 32'(toggles), 32'(hold / (DB + 1)));
      checkOutput("collGoHigh", 32'(goHigh), 32'(0));
      BMPL_n = 1'b1;
      tick(2);
      checkOutput("releaseBuzz", 32'(buzz), 32'(0));
      checkOutput("releaseGo", 32'(go), 32'(1));
      BMPR_n = 1'b0; line_present = 1'b0;
      tick(3);
      checkOutput("prioBuzz", 32'(buzz), 32'(1));
      checkOutput("prioGo", 32'(go), 32'(0));
      checkOutput("prioErr", 32'(err_opn_lp), 32'(0));
      line_present = 1'b1; BMPR_n = 1'b1;
      tick(3);
      checkOutput("prioRelGo", 32'(go), 32'(1));
      checkOutput("prioRelBuzz", 32'(buzz), 32'(0));
      runQueue();

      for (int r = 0; r < 6; r++) begin
         int k;
         k = $urandom_range(1, 3);
         for (int i = 0; i < k; i++) applyStimulus(randWord());
         startFromIdle();
         runQueue();
      end

      applyStimulus(16'h9999);
      startFromIdle();
      runQueue();

`ifdef LINE_TIMEOUT_EN
      applyStimulus(16'h0001);
      applyStimulus(16'h0002);
      startFromIdle();
      line_present = 1'b0;
      tick(LOST + 20);
      checkOutput("abortSet", 32'(aborted), 32'(1));
      checkOutput("abortEmpty", 32'(fifo_empty), 32'(1));
      checkOutput("abortGo", 32'(go), 32'(0));
      checkOutput("abortErr", 32'(err_opn_lp), 32'(0));
      wordQ.delete();
      applyStimulus(16'h0001);
      checkOutput("abortCleared", 32'(aborted), 32'(0));
      startFromIdle();
      runQueue();
`else
      checkOutput("abortedTied", 32'(aborted), 32'(0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
